// File: rtl/debounce_bank_pkg.sv
// Shared constants and width helpers for the debounce bank.
// Optional auto-repeat is controlled by the DEBOUNCE_REPEAT_EN macro (see db_channel).
package debounce_bank_pkg;

    localparam int DB_CHANNELS_DEFAULT     = 2;
    localparam int DB_TICK_DIV_DEFAULT     = 100000;
    localparam int DB_STABLE_TICKS_DEFAULT = 8;
    localparam int DB_REPEAT_DELAY_DEFAULT = 500;
    localparam int DB_REPEAT_RATE_DEFAULT  = 100;

    // Width of a counter that must hold values 0..max_val.
    function automatic int db_cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int db_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-FF synchroniser, tick-sampled stability filter, edge pulses.
// With DEBOUNCE_REPEAT_EN defined it also builds the held-button auto-repeat counter.
module db_channel
    import debounce_bank_pkg::*;
#(
    parameter int STABLE_TICKS = DB_STABLE_TICKS_DEFAULT
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = DB_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE  = DB_REPEAT_RATE_DEFAULT
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_repeat
);

    localparam int                STAB_W    = db_cnt_width(STABLE_TICKS);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

    logic              r_sync0;
    logic              r_sync1;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [STAB_W-1:0] w_stab_cnt_next;
    logic              r_level;
    logic              w_level_next;
    logic              r_rise;
    logic              w_rise_next;
    logic              r_fall;
    logic              w_fall_next;
    logic              w_differs;
    logic              w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
        end
    end

    assign w_differs = (r_sync1 != r_level);
    assign w_accept  = i_tick && w_differs && (r_stab_cnt == STAB_LAST);

    // Any sample matching the current level restarts the run of differing samples.
    always_comb begin
        w_stab_cnt_next = r_stab_cnt;
        w_level_next    = r_level;
        w_rise_next     = 1'b0;
        w_fall_next     = 1'b0;
        if (w_accept) begin
            w_level_next    = ~r_level;
            w_stab_cnt_next = '0;
            w_rise_next     = ~r_level;
            w_fall_next     = r_level;
        end else if (i_tick) begin
            if (!w_differs) begin
                w_stab_cnt_next = '0;
            end else begin
                w_stab_cnt_next = r_stab_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stab_cnt <= '0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_stab_cnt <= w_stab_cnt_next;
            r_level    <= w_level_next;
            r_rise     <= w_rise_next;
            r_fall     <= w_fall_next;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int               REP_W     = db_cnt_width(db_max(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_next;
    logic [REP_W-1:0] w_rep_inc;
    logic [REP_W-1:0] w_rep_limit;
    logic             r_rep_armed;
    logic             w_rep_armed_next;
    logic             r_repeat;
    logic             w_repeat_next;

    // First interval is REPEAT_DELAY ticks, later ones REPEAT_RATE; the
    // counter only advances while the accepted level is already high.
    always_comb begin
        w_rep_cnt_next   = r_rep_cnt;
        w_rep_armed_next = r_rep_armed;
        w_repeat_next    = 1'b0;
        w_rep_inc        = r_rep_cnt + 1'b1;
        w_rep_limit      = r_rep_armed ? REP_RATE : REP_DELAY;
        if (!r_level || w_accept) begin
            w_rep_cnt_next   = '0;
            w_rep_armed_next = 1'b0;
        end else if (i_tick) begin
            if (w_rep_inc >= w_rep_limit) begin
                w_repeat_next    = 1'b1;
                w_rep_cnt_next   = '0;
                w_rep_armed_next = 1'b1;
            end else begin
                w_rep_cnt_next = w_rep_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_rep_cnt   <= w_rep_cnt_next;
            r_rep_armed <= w_rep_armed_next;
            r_repeat    <= w_repeat_next;
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer/edge detector with a shared sample tick.
// Define DEBOUNCE_REPEAT_EN to build auto-repeat pulses; otherwise repeat_pulse is 0.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int CHANNELS     = DB_CHANNELS_DEFAULT,
    parameter int TICK_DIV     = DB_TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = DB_STABLE_TICKS_DEFAULT,
    parameter int REPEAT_DELAY = DB_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE  = DB_REPEAT_RATE_DEFAULT
) (
    input  logic                board_clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int                TICK_W    = db_cnt_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    generate
        if (CHANNELS < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 ||
            REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("debounce_bank: parameter out of range");
        end
    endgenerate

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            db_channel #(
                .STABLE_TICKS (STABLE_TICKS)
`ifdef DEBOUNCE_REPEAT_EN
                ,
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE)
`endif
            ) u_ch (
                .clk      (board_clk),
                .rst      (reset),
                .i_tick   (w_tick),
                .i_raw    (in_raw[gi]),
                .o_level  (level[gi]),
                .o_rise   (rise_pulse[gi]),
                .o_fall   (fall_pulse[gi]),
                .o_repeat (repeat_pulse[gi])
            );
        end
    endgenerate

endmodule
